// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// The LAP state exists only when STOPWATCH_LAP_EN is defined.
package stopwatch_pkg;

`ifdef STOPWATCH_LAP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;
`endif

    // Per-digit wrap limits: tenths, seconds, ten-seconds, minutes
    localparam logic [3:0] D0_MAX = 4'd9;
    localparam logic [3:0] D1_MAX = 4'd9;
    localparam logic [3:0] D2_MAX = 4'd5;
    localparam logic [3:0] D3_MAX = 4'd9;

    localparam int DEF_TICK_DIV   = 10000000;
    localparam int DEF_SCAN_DIV   = 2500000;
    localparam int DEF_DEB_CYCLES = 200000;

endpackage

// File: rtl/btn_pulse.sv
// Raw button conditioning: 2-flop synchronizer, level debouncer and a
// one-cycle press pulse on each accepted 0->1 change.
module btn_pulse #(
    parameter int DEB_CYCLES = stopwatch_pkg::DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_p0, sync_p1;
    logic          vld_p0, vld_p1;
    logic          armed;
    logic          deb_lvl, deb_d;
    logic [CW-1:0] deb_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            armed   <= 1'b0;
            deb_lvl <= 1'b0;
            deb_d   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            // A button held through reset must be seen released before it can fire
            if (vld_p1 && !sync_p1)
                armed <= 1'b1;
            deb_d <= deb_lvl;
            if (sync_p1 == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_lvl <= sync_p1;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign pulse = deb_lvl & ~deb_d & armed;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch: start/stop and lap/clear buttons, 0.1 s BCD count, 4-digit scan.
// Lap freeze display is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int SCAN_DIV   = DEF_SCAN_DIV,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic [2:0] hexplay_an,
    output logic [3:0] hexplay_data,
    output logic       running,
    output logic       lap_active
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);

    state_t        state, state_nxt;
    logic          start_p, lap_p;
    logic          clear;
    logic [PW-1:0] presc;
    logic [15:0]   count;
    logic [15:0]   disp;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    an_p0;

    // Ripple BCD increment of {d3,d2,d1,d0}; 9:59.9 rolls to 0:00.0
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != D0_MAX) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != D1_MAX) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (v[11:8] != D2_MAX) begin
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = (v[15:12] != D3_MAX) ? v[15:12] + 4'd1 : 4'd0;
                end
            end
        end
        return r;
    endfunction

    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_start (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_start),
        .pulse (start_p)
    );

    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_lap),
        .pulse (lap_p)
    );

`ifdef STOPWATCH_LAP_EN
    logic        capture;
    logic [15:0] lap_reg;
`endif

    // Start is tested first everywhere, so it wins over a simultaneous lap
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
`ifdef STOPWATCH_LAP_EN
        capture   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start_p) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (start_p) begin
                    state_nxt = ST_PAUSE;
                end
`ifdef STOPWATCH_LAP_EN
                else if (lap_p) begin
                    state_nxt = ST_LAP;
                    capture   = 1'b1;
                end
            end
            ST_LAP: begin
                if (start_p)    state_nxt = ST_PAUSE;
                else if (lap_p) state_nxt = ST_RUN;
`endif
            end
            ST_PAUSE: begin
                if (start_p) begin
                    state_nxt = ST_RUN;
                end else if (lap_p) begin
                    state_nxt = ST_IDLE;
                    clear     = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    assign running    = (state == ST_RUN) || (state == ST_LAP);
    assign lap_active = (state == ST_LAP);
    assign disp       = lap_active ? lap_reg : count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lap_reg <= '0;
        else if (capture)
            lap_reg <= count;
    end
`else
    assign running    = (state == ST_RUN);
    assign lap_active = 1'b0;
    assign disp       = count;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            presc <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                presc <= '0;
                count <= '0;
            end else if (running) begin
                if (presc == P_LAST) begin
                    presc <= '0;
                    count <= bcd_inc(count);
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    // Digit scan: data register lags the digit index by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt     <= '0;
            an_p0        <= 2'd0;
            hexplay_data <= 4'd0;
        end else begin
            if (scan_cnt == S_LAST) begin
                scan_cnt <= '0;
                an_p0    <= an_p0 + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            hexplay_data <= disp[{an_p0, 2'b00} +: 4];
        end
    end

    assign hexplay_an = {1'b0, an_p0};

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with small dividers (tick 4, scan 2, debounce 3).
// Lap-specific expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic [2:0] hexplay_an;
    logic [3:0] hexplay_data;
    logic       running;
    logic       lap_active;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_ctrl #(
        .TICK_DIV   (4),
        .SCAN_DIV   (2),
        .DEB_CYCLES (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_start    (btn_start),
        .btn_lap      (btn_lap),
        .hexplay_an   (hexplay_an),
        .hexplay_data (hexplay_data),
        .running      (running),
        .lap_active   (lap_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cnt(input string tag, input logic [15:0] v, input int budget);
        int i;
        i = 0;
        while (dut.count !== v && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, dut.count, v);
    endtask

    // Assemble all four displayed digits; data at each sample belongs to the previous index
    task automatic read_disp(output logic [15:0] d);
        logic [1:0] pa;
        d  = '0;
        pa = hexplay_an[1:0];
        repeat (10) begin
            @(negedge clk);
            d[{pa, 2'b00} +: 4] = hexplay_data;
            pa = hexplay_an[1:0];
        end
    endtask

    initial begin : main
        logic [15:0] d;
        logic [1:0]  pa;
        logic [3:0]  exp_an   [9];
        logic [3:0]  exp_data [9];

        exp_an   = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0};
        exp_data = '{4'd0, 4'd8, 4'd8, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        d  = '0;
        pa = 2'd0;

        // Reset state
        cyc(3);
        chk("rst_an", hexplay_an, 0);
        chk("rst_data", hexplay_data, 0);
        chk("rst_running", running, 0);
        chk("rst_lap_active", lap_active, 0);
        chk("rst_count", dut.count, 0);
        rst = 1'b1;
        cyc(5);

        // First start press: debounce latency, then first tick 4 cycles later
        btn_start = 1'b1;
        cyc(5);
        chk("start_debouncing", running, 0);
        cyc(1);
        chk("start_running", running, 1);
        cyc(3);
        chk("count_before_tick", dut.count, 16'h0000);
        cyc(1);
        chk("count_first_tick", dut.count, 16'h0001);
        btn_start = 1'b0;

        // Full-range wrap
        wait_cnt("reach_9598", 16'h9598, 30000);
        cyc(4);
        chk("count_9599", dut.count, 16'h9599);
        cyc(4);
        chk("wrap_to_zero", dut.count, 16'h0000);
        chk("wrap_still_running", running, 1);

        // Lap at 0:01.2, lap again at 0:01.5, then pause one cycle later
        wait_cnt("reach_0011", 16'h0011, 100);
        btn_lap = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c >= 7 && c <= 17)
                d[{pa, 2'b00} +: 4] = hexplay_data;
            pa = hexplay_an[1:0];
`ifdef STOPWATCH_LAP_EN
            if (c == 5)  chk("lap_not_yet", lap_active, 0);
            if (c == 6)  chk("lap_entered", lap_active, 1);
            if (c == 16) chk("lap_live_count", dut.count, 16'h0015);
            if (c == 16) chk("lap_still_active", lap_active, 1);
            if (c == 17) chk("lap_back_to_run", lap_active, 0);
            if (c == 17) chk("lap_run_running", running, 1);
`else
            if (c == 7)  chk("lap_ignored_running", running, 1);
            if (c == 7)  chk("lap_ignored_flag", lap_active, 0);
            if (c == 16) chk("live_count_0015", dut.count, 16'h0015);
`endif
            if (c == 18) chk("paused_running", running, 0);
            if (c == 18) chk("paused_lap_flag", lap_active, 0);
            if (c == 6)  btn_lap = 1'b0;
            if (c == 11) btn_lap = 1'b1;
            if (c == 12) btn_start = 1'b1;
            if (c == 18) begin
                btn_lap   = 1'b0;
                btn_start = 1'b0;
            end
        end
`ifdef STOPWATCH_LAP_EN
        chk("lap_frozen_display", d, 16'h0012);
`endif
        read_disp(d);
        chk("pause_display", d, 16'h0015);
        chk("pause_count", dut.count, 16'h0015);

        // Resume, then start and lap in the same cycle
        btn_start = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 5)  chk("resume_pending", running, 0);
            if (c == 6)  chk("resume_running", running, 1);
            if (c == 16) chk("both_pending", running, 1);
            if (c == 17) begin
                chk("both_paused", running, 0);
                chk("both_no_lap", lap_active, 0);
                chk("both_count_kept", dut.count, 16'h0018);
            end
            if (c == 6) btn_start = 1'b0;
            if (c == 11) begin
                btn_start = 1'b1;
                btn_lap   = 1'b1;
            end
            if (c == 17) begin
                btn_start = 1'b0;
                btn_lap   = 1'b0;
            end
        end
        cyc(8);
        chk("pause_hold_count", dut.count, 16'h0018);
        chk("pause_hold_presc", dut.presc, 1);

        // Scan order and one-cycle data lag, displaying 0:01.8
        pa = hexplay_an[1:0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hexplay_an == 3'd0 && pa == 2'd3) break;
            pa = hexplay_an[1:0];
        end
        for (int s = 0; s < 9; s++) begin
            if (s > 0) @(negedge clk);
            chk($sformatf("scan_an_%0d", s), hexplay_an, exp_an[s]);
            chk($sformatf("scan_data_%0d", s), hexplay_data, exp_data[s]);
        end

        // Lap press in PAUSE clears to IDLE
        btn_lap = 1'b1;
        cyc(5);
        chk("clear_pending", dut.count, 16'h0018);
        cyc(1);
        chk("clear_count", dut.count, 16'h0000);
        chk("clear_presc", dut.presc, 0);
        chk("clear_running", running, 0);
        btn_lap = 1'b0;
        read_disp(d);
        chk("idle_display", d, 16'h0000);

        // Start from IDLE, then asynchronous reset mid-run with start held
        btn_start = 1'b1;
        cyc(6);
        chk("idle_to_run", running, 1);
        cyc(7);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_running", running, 0);
        chk("async_rst_an", hexplay_an, 0);
        chk("async_rst_data", hexplay_data, 0);
        chk("async_rst_lap", lap_active, 0);
        chk("async_rst_count", dut.count, 0);
        cyc(3);
        rst = 1'b1;
        cyc(20);
        chk("held_no_pulse", running, 0);
        btn_start = 1'b0;
        cyc(8);
        btn_start = 1'b1;
        cyc(6);
        chk("press_after_release", running, 1);
        btn_start = 1'b0;
        cyc(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10000000, meaning clk cycles per 0.1 s count tick.
REQ-002 SHALL have parameter SCAN_DIV, default 2500000, meaning clk cycles per display digit slot.
REQ-003 SHALL have parameter DEB_CYCLES, default 200000, meaning the stable-level cycles required to accept a button change.
REQ-004 SHALL have port clk, input, width 1: single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, width 1: asynchronous active-low reset.
REQ-006 SHALL have port btn_start, input, width 1: asynchronous raw start/stop button, active-high.
REQ-007 SHALL have port btn_lap, input, width 1: asynchronous raw lap/clear button, active-high.
REQ-008 SHALL have port hexplay_an, output, width 3: selected digit index 0..3.
REQ-009 SHALL have port hexplay_data, output, width 4: BCD value of the selected digit.
REQ-010 SHALL have port running, output, width 1: high in RUN or LAP.
REQ-011 SHALL have port lap_active, output, width 1: high in LAP.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer and a DEB_CYCLES debouncer, then generate a one-cycle press pulse on the accepted 0->1 transition.
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE and LAP.
REQ-014 SHALL transition IDLE->RUN on a start pulse and ignore lap pulses in IDLE.
REQ-015 SHALL transition RUN->PAUSE on a start pulse and RUN->LAP on a lap pulse, capturing the live count into the lap register in the same edge.
REQ-016 SHALL transition LAP->RUN on a lap pulse (display returns to live) and LAP->PAUSE on a start pulse (display returns to live).
REQ-017 SHALL transition PAUSE->RUN on a start pulse and PAUSE->IDLE on a lap pulse, clearing count and prescaler to 0.
REQ-018 SHALL let a start pulse win and drop the lap pulse when both pulses occur in the same cycle.
REQ-019 SHALL advance the prescaler only in RUN/LAP, hold it in PAUSE, and increment the count when the prescaler equals TICK_DIV-1, then wrap the prescaler to 0.
REQ-020 SHALL hold the count as four BCD digits (d0 tenths 0-9, d1 seconds 0-9, d2 ten-seconds 0-5, d3 minutes 0-9) with ripple carry in one cycle; 9:59.9 SHALL wrap to 0:00.0.
REQ-021 SHALL keep the count advancing while in LAP, with only the display frozen.
REQ-022 SHALL run a free-running scan counter that advances hexplay_an 0->1->2->3->0 every SCAN_DIV cycles in all states.
REQ-023 SHALL register hexplay_data as digit[hexplay_an] of the displayed value (lap register in LAP, live count otherwise), with a latency of one cycle after hexplay_an changes.
REQ-024 SHALL never produce hexplay_an values 4-7 or non-BCD hexplay_data.

Reset
REQ-025 SHALL, while rst is low, force the state to IDLE, and the count, lap register, prescaler, scan counter, debouncers, hexplay_an, hexplay_data, running and lap_active to 0, regardless of clk.
REQ-026 SHALL discard any press pending at reset assertion so that no pulse is generated on deassertion while a button is held.

Configuration
REQ-027 SHALL compile the lap feature only when macro STOPWATCH_LAP_EN is defined.
REQ-028 SHALL, without STOPWATCH_LAP_EN, omit the LAP state and lap register, ignore lap pulses in RUN, tie lap_active to 0, and still clear the count on a lap pulse in PAUSE.

Structure
REQ-029 SHALL place the state enum, the digit limit constants (9, 9, 5, 9) and the default divider values in shared package stopwatch_pkg.
REQ-030 SHALL implement synchronizer, debouncer and edge pulse in one sub-module, btn_pulse, instantiated twice.

Verification (TICK_DIV=4, SCAN_DIV=2, DEB_CYCLES=3)
REQ-031 SHALL cover: start press -> running=1 after debounce, count 0:00.1 after 4 further cycles.
REQ-032 SHALL cover: run from 9:59.8 for 2 ticks -> 0:00.0, with no carry out.
REQ-033 SHALL cover: lap at 0:01.2, then 3 ticks -> display digits 2,1,0,0 while the live count is 0:01.5; lap again -> display shows 5,1,0,0.
REQ-034 SHALL cover: start and lap pulses in the same cycle from RUN -> PAUSE, lap_active=0.
REQ-035 SHALL cover: PAUSE, then lap press -> IDLE with all digits 0; rst low mid-RUN -> every output 0 immediately (asynchronously).
REQ-036 SHALL cover: the scan sequence 0,1,2,3,0 on hexplay_an every 2 cycles, with hexplay_data following one cycle later.
